// File: rtl/dm_arbiter_pkg.sv
// Shared types for the M-stage data-memory arbiter: FSM state encoding,
// requester identifiers, the latched memory command and counter sizing.
package dm_arbiter_pkg;

  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_PIPE = 1'b0,
    REQ_SEC  = 1'b1
  } req_id_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [1:0]  op_width;
    logic        load_signed;
  } mem_cmd_t;

  // The counter only ever holds LATENCY-1, but a zero-width vector is illegal.
  function automatic int cnt_width(input int latency);
    return ($clog2(latency) < 1) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the pipeline, secondary-master and memory-port signals around
// dm_arbiter. The arbiter takes the slave view, its environment the master view.
interface dm_arbiter_if;

  // Pipeline M-stage requester
  logic        preq;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] ppc;
  logic [1:0]  popwidth;
  logic        ploadsigned;
  logic        pstall;
  logic        pdone;
  logic [31:0] prdata;

  // Secondary bus master (DMA / debug)
  logic        dreq;
  logic        dwrite;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [1:0]  dopwidth;
  logic        dgnt;
  logic        ddone;
  logic [31:0] drdata;

  // Shared memory port
  logic        memen;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwd;
  logic [31:0] mempc;
  logic [1:0]  memopwidth;
  logic        memloadsigned;
  logic [31:0] memrd;

  modport slave (
    input  preq, pwrite, paddr, pwdata, ppc, popwidth, ploadsigned,
    output pstall, pdone, prdata,
    input  dreq, dwrite, daddr, dwdata, dopwidth,
    output dgnt, ddone, drdata,
    output memen, memwrite, memaddr, memwd, mempc, memopwidth, memloadsigned,
    input  memrd
  );

  modport master (
    output preq, pwrite, paddr, pwdata, ppc, popwidth, ploadsigned,
    input  pstall, pdone, prdata,
    output dreq, dwrite, daddr, dwdata, dopwidth,
    input  dgnt, ddone, drdata,
    input  memen, memwrite, memaddr, memwd, mempc, memopwidth, memloadsigned,
    output memrd
  );

endinterface

// File: rtl/dm_arbiter_access_counter.sv
// Loadable down-counter that times a memory access; zero marks the final
// access cycle. It stops at zero rather than wrapping.
module access_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter and sequencer for the shared M-stage data memory:
// one access at a time, command held for LATENCY cycles, one-cycle done pulse.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  localparam int             CW       = cnt_width(LATENCY);
  localparam logic [CW-1:0]  LOAD_VAL = CW'(LATENCY - 1);

  state_t   state, state_nxt;
  req_id_t  owner;        // granted requester; doubles as the last-grant flag
  mem_cmd_t cmd;
  logic [31:0] prdata_q, drdata_q;

  req_id_t  grant_id;
  logic     grant_valid;
  mem_cmd_t grant_cmd;
  logic     cnt_load, cnt_zero, final_cycle;

  // Round-robin: on a tie the requester that was not granted last wins.
  always_comb begin
    grant_valid = bus.preq | bus.dreq;
    grant_id    = REQ_PIPE;
    if (bus.preq && bus.dreq) begin
      grant_id = (owner == REQ_PIPE) ? REQ_SEC : REQ_PIPE;
    end else if (bus.dreq) begin
      grant_id = REQ_SEC;
    end
  end

  // The secondary master has no PC or sign-extend input; both read as zero.
  always_comb begin
    if (grant_id == REQ_PIPE) begin
      grant_cmd = '{write:       bus.pwrite,
                    addr:        bus.paddr,
                    wdata:       bus.pwdata,
                    pc:          bus.ppc,
                    op_width:    bus.popwidth,
                    load_signed: bus.ploadsigned};
    end else begin
      grant_cmd = '{write:       bus.dwrite,
                    addr:        bus.daddr,
                    wdata:       bus.dwdata,
                    pc:          32'd0,
                    op_width:    bus.dopwidth,
                    load_signed: 1'b0};
    end
  end

  // NOTE: every output of this always_comb gets a default before the case,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_nxt = ST_ACCESS;
          cnt_load  = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  access_counter #(.WIDTH(CW)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (LOAD_VAL),
    .en         (state == ST_ACCESS),
    .zero       (cnt_zero)
  );

  assign final_cycle = (state == ST_ACCESS) && cnt_zero;

  // NOTE: the command and read-data registers are explicitly cleared on
  // reset so no stale address or data is visible after an aborted access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= REQ_SEC;
      cmd      <= '0;
      prdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && grant_valid) begin
        owner <= grant_id;
        cmd   <= grant_cmd;
      end
      // Stores leave the requester's read data untouched.
      if (final_cycle && !cmd.write) begin
        if (owner == REQ_PIPE) prdata_q <= bus.memrd;
        else                   drdata_q <= bus.memrd;
      end
    end
  end

  assign bus.memen         = (state == ST_ACCESS);
  assign bus.memwrite      = final_cycle && cmd.write;
  assign bus.memaddr       = cmd.addr;
  assign bus.memwd         = cmd.wdata;
  assign bus.mempc         = cmd.pc;
  assign bus.memopwidth    = cmd.op_width;
  assign bus.memloadsigned = cmd.load_signed;

  assign bus.pdone  = (state == ST_DONE) && (owner == REQ_PIPE);
  assign bus.ddone  = (state == ST_DONE) && (owner == REQ_SEC);
  assign bus.dgnt   = ((state == ST_ACCESS) || (state == ST_DONE)) && (owner == REQ_SEC);
  assign bus.pstall = bus.preq & ~bus.pdone;
  assign bus.prdata = prdata_q;
  assign bus.drdata = drdata_q;

endmodule
